// File: rtl/down_counter.sv
// Loadable, pausable down-counter/timer with a one-cycle done pulse.
// Ports: clk, rst (async high), load/load_val, start, pause, stop -> count, busy, done.
// Option: define DOWN_COUNTER_AUTO_RELOAD_EN for periodic reload from reload_reg.
module down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_n;
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] reload_n;
  logic             done_q;
  logic             done_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      count_q  <= count_n;
      reload_q <= reload_n;
      done_q   <= done_n;
    end
  end

  // Priority: load > stop > start > pause. done is a pulse, so it
  // defaults low and is only raised on the terminal edge.
  always_comb begin
    state_n  = state;
    count_n  = count_q;
    reload_n = reload_q;
    done_n   = 1'b0;
    if (load) begin
      count_n  = load_val;
      reload_n = load_val;
      state_n  = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!stop && start) begin
            // A zero-length run completes immediately without going busy.
            if (count_q != '0) state_n = RUN;
            else               done_n  = 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state_n = IDLE;
          end else if (pause) begin
            state_n = HOLD;
          end else if (count_q > WIDTH'(1)) begin
            count_n = count_q - WIDTH'(1);
          end else begin
            done_n = 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            count_n = reload_q;
`else
            count_n = '0;
            state_n = FIN;
`endif
          end
        end
        HOLD: begin
          if (stop)        state_n = IDLE;
          else if (!pause) state_n = RUN;
        end
        FIN: begin
          state_n = IDLE;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  assign count = count_q;
  assign done  = done_q;
  assign busy  = (state == RUN) || (state == HOLD);

endmodule

// File: tb/tb_down_counter.sv
// Directed self-checking bench for down_counter (default one-shot build).
// Drives steps #1 after each rising edge and checks there.
module tb_down_counter;

  logic       clk;
  logic       rst;
  logic       load;
  logic [3:0] load_val;
  logic       start;
  logic       pause;
  logic       stop;
  logic [3:0] count;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  down_counter #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .pause    (pause),
    .stop     (stop),
    .count    (count),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input int c, input int b, input int d);
    chk({tag, ".count"}, 32'(count), c);
    chk({tag, ".busy"}, 32'(busy), b);
    chk({tag, ".done"}, 32'(done), d);
  endtask

  initial begin
    rst = 1'b1;
    load = 1'b0;
    load_val = 4'd0;
    start = 1'b0;
    pause = 1'b0;
    stop = 1'b0;

    // Reset
    tick();
    tick();
    chk3("rst_hold", 0, 0, 0);
    rst = 1'b0;
    tick();
    chk3("rst_rel", 0, 0, 0);

    // One-shot from 5
    load = 1'b1; load_val = 4'd5;
    tick();
    load = 1'b0;
    chk3("os_load", 5, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk3("os_start", 5, 1, 0);
    for (int k = 4; k >= 1; k--) begin
      tick();
      chk3("os_run", k, 1, 0);
    end
    tick();
    chk3("os_done", 0, 0, 1);
    // start held in DONE must be ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    chk3("os_after", 0, 0, 0);

    // Pause from 9: 9+4+1 edges total
    load = 1'b1; load_val = 4'd9;
    tick();
    load = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk3("pz_start", 9, 1, 0);
    for (int k = 8; k >= 6; k--) begin
      tick();
      chk3("pz_run", k, 1, 0);
    end
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk3("pz_hold", 6, 1, 0);
    end
    pause = 1'b0;
    tick();
    chk3("pz_resume", 6, 1, 0);
    for (int k = 5; k >= 1; k--) begin
      tick();
      chk3("pz_run2", k, 1, 0);
    end
    tick();
    chk3("pz_done", 0, 0, 1);
    tick();
    chk3("pz_after", 0, 0, 0);

    // Zero-length start
    load = 1'b1; load_val = 4'd0;
    tick();
    load = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk3("zero_done", 0, 0, 1);
    tick();
    chk3("zero_after", 0, 0, 0);

    // Stop at 4 and resume
    load = 1'b1; load_val = 4'd8;
    tick();
    load = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 7; k >= 4; k--) begin
      tick();
      chk3("sp_run", k, 1, 0);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk3("sp_stop", 4, 0, 0);
    tick();
    chk3("sp_idle", 4, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk3("sp_restart", 4, 1, 0);
    for (int k = 3; k >= 1; k--) begin
      tick();
      chk3("sp_run2", k, 1, 0);
    end
    tick();
    chk3("sp_done", 0, 0, 1);
    tick();

    // load beats start on the same edge
    load = 1'b1; load_val = 4'd3; start = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    chk3("ld_prio", 3, 0, 0);

    // Async reset mid-run
    load = 1'b1; load_val = 4'd15;
    tick();
    load = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 14; k >= 7; k--) begin
      tick();
    end
    chk3("ar_pre", 7, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    chk3("ar_async", 0, 0, 0);
    tick();
    rst = 1'b0;
    tick();
    chk3("ar_after", 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
